// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array operand feeder.
package sa_pkg;

   localparam int DATA_W     = 16;
   localparam int LANES      = 4;
   localparam int MEM_ROWS   = 32;

   // Lane-slice helper widths
   localparam int ROW_IDX_W  = $clog2(MEM_ROWS);
   localparam int LANE_IDX_W = $clog2(LANES);
   localparam int LANE_BUS_W = LANES * DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth delay line for one lane's {valid, data}; depth 0 is a plain wire.
module sa_skew_line #(
   parameter int DEPTH = 0,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vld_i,
   input  logic [W-1:0] data_i,
   output logic         vld_o,
   output logic [W-1:0] data_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk & rst_n;
      assign vld_o  = vld_i;
      assign data_o = data_i;
   end else begin : g_pipe
      logic [DEPTH-1:0] vld_q;
      logic [W-1:0]     data_q [DEPTH];

      // Shift valid and data one stage per cycle
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
         end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
               vld_q[i]  <= vld_q[i-1];
               data_q[i] <= data_q[i-1];
            end
         end
      end

      assign vld_o  = vld_q[DEPTH-1];
      assign data_o = data_q[DEPTH-1];
   end

endmodule

// File: rtl/sa_row_feeder.sv
// Row feeder: walks a range of operand-memory rows, assembles each row and
// launches it into the systolic-array lanes.
// Build option: FEEDER_SKEW_EN adds a k-stage delay on lane k (diagonal wavefront).
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one memory address per cycle
// DRAIN | waiting for the read pipeline and skew lines to empty
// DONE  | one cycle; done pulses on the following cycle
module sa_row_feeder
   import sa_pkg::*;
#(
   parameter int ROW_W = 32,
   parameter int COL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ROW_IDX_W-1:0]  base_row,
   input  logic [ROW_IDX_W:0]    num_rows,
   output logic                  busy,
   output logic                  done,
   output logic [ROW_W-1:0]      mem_row,
   output logic [COL_W-1:0]      mem_col,
   output logic                  mem_en,
   input  logic [DATA_W-1:0]     mem_data,
   output logic [LANE_BUS_W-1:0] lane_data,
   output logic [LANES-1:0]      lane_valid
);

`ifdef FEEDER_SKEW_EN
   localparam int SKEW_MAX = LANES - 1;
`else
   localparam int SKEW_MAX = 0;
`endif

   feeder_state_e         state_q;
   logic                  busy_q;
   logic                  done_q;
   logic [ROW_IDX_W-1:0]  addr_row_q;
   logic [ROW_IDX_W-1:0]  row_next_d;
   logic [LANE_IDX_W-1:0] addr_col_q;
   logic                  addr_vld_q;
   logic [ROW_IDX_W:0]    rows_left_q;
   logic [LANE_IDX_W-1:0] drain_cnt_q;

   logic                  rd_vld_q;
   logic [LANE_IDX_W-1:0] rd_col_q;
   logic                  row_last;
   logic [DATA_W-1:0]     row_buf_q [LANES-1];
   logic [LANE_BUS_W-1:0] launch_data_d;
   logic [LANE_BUS_W-1:0] launch_data_q;
   logic                  launch_vld_q;

   assign row_next_d = (addr_row_q == ROW_IDX_W'(MEM_ROWS - 1)) ? '0 : addr_row_q + 1'b1;

   // Sequencer: accepts start, issues addresses, waits out the pipeline latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_row_q  <= '0;
         addr_col_q  <= '0;
         addr_vld_q  <= 1'b0;
         rows_left_q <= '0;
         drain_cnt_q <= '0;
      end else begin
         done_q <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (num_rows != '0) begin
                     state_q     <= FETCH;
                     busy_q      <= 1'b1;
                     addr_row_q  <= base_row;
                     addr_col_q  <= '0;
                     addr_vld_q  <= 1'b1;
                     rows_left_q <= num_rows - 1'b1;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            FETCH: begin
               if (addr_col_q == LANE_IDX_W'(LANES - 1)) begin
                  if (rows_left_q == '0) begin
                     addr_vld_q  <= 1'b0;
                     drain_cnt_q <= LANE_IDX_W'(SKEW_MAX);
                     state_q     <= DRAIN;
                  end else begin
                     rows_left_q <= rows_left_q - 1'b1;
                     addr_row_q  <= row_next_d;
                     addr_col_q  <= '0;
                  end
               end else begin
                  addr_col_q <= addr_col_q + 1'b1;
               end
            end
            DRAIN: begin
               // The last launch is already in flight; only the skew tail remains
               if (drain_cnt_q == '0) state_q <= DONE;
               else                   drain_cnt_q <= drain_cnt_q - 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign row_last = rd_vld_q && (rd_col_q == LANE_IDX_W'(LANES - 1));

   // Full row: buffered columns plus the last column taken straight off the read port
   always_comb begin
      launch_data_d = '0;
      for (int k = 0; k < LANES - 1; k++) launch_data_d[k*DATA_W +: DATA_W] = row_buf_q[k];
      launch_data_d[(LANES-1)*DATA_W +: DATA_W] = mem_data;
   end

   // Read-return capture and row launch; data is zero whenever not launching
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q      <= 1'b0;
         rd_col_q      <= '0;
         launch_vld_q  <= 1'b0;
         launch_data_q <= '0;
         for (int k = 0; k < LANES - 1; k++) row_buf_q[k] <= '0;
      end else begin
         rd_vld_q      <= addr_vld_q;
         rd_col_q      <= addr_col_q;
         launch_vld_q  <= row_last;
         launch_data_q <= row_last ? launch_data_d : '0;
         for (int k = 0; k < LANES - 1; k++) begin
            if (rd_vld_q && (rd_col_q == LANE_IDX_W'(k))) row_buf_q[k] <= mem_data;
         end
      end
   end

`ifdef FEEDER_SKEW_EN
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sa_skew_line #(
         .DEPTH (k),
         .W     (DATA_W)
      ) u_skew (
         .clk    (clk),
         .rst_n  (rst_n),
         .vld_i  (launch_vld_q),
         .data_i (launch_data_q[k*DATA_W +: DATA_W]),
         .vld_o  (lane_valid[k]),
         .data_o (lane_data[k*DATA_W +: DATA_W])
      );
   end
`else
   assign lane_valid = {LANES{launch_vld_q}};
   assign lane_data  = launch_data_q;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign mem_row = ROW_W'(addr_row_q);
   assign mem_col = COL_W'(addr_col_q);
   assign mem_en  = 1'b0;

endmodule

// File: tb/tb_sa_row_feeder.sv
// Bench for sa_row_feeder: table of directed jobs, a mid-fetch reset sequence
// and randomized jobs, all compared against a per-cycle behavioural model.
module tb_sa_row_feeder;

`ifdef FEEDER_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif
   localparam int NL = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  base_row;
   logic [5:0]  num_rows;
   logic        busy;
   logic        done;
   logic [31:0] mem_row;
   logic [3:0]  mem_col;
   logic        mem_en;
   logic [15:0] mem_data;
   logic [63:0] lane_data;
   logic [3:0]  lane_valid;

   logic [15:0] mem_q [32][4];

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      int          base;
      int          num;
      int          rs_t;
      int          rbase;
      int          rnum;
      logic [15:0] e_first;
      logic [15:0] e_last;
      logic        addr_zero;
   } vec_t;

   vec_t tbl [6];

   sa_row_feeder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_row   (base_row),
      .num_rows   (num_rows),
      .busy       (busy),
      .done       (done),
      .mem_row    (mem_row),
      .mem_col    (mem_col),
      .mem_en     (mem_en),
      .mem_data   (mem_data),
      .lane_data  (lane_data),
      .lane_valid (lane_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read operand memory
   always @(posedge clk) mem_data <= mem_q[mem_row[4:0]][mem_col[1:0]];

   task automatic chk(input string name, input int t, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s t=%0d: got %h, expected %h", name, t, got, exp);
      end
   endtask

   function automatic int t_done(input int n);
      if (n == 0) return 1;
      return 5 + 4 * (n - 1) + (NL - 1) * SKEW + 1;
   endfunction

   // Row r reaches lane k in the cycle after edge 5+4r (+k when skewed)
   task automatic model_lanes(input int t, input int b, input int n,
                              output logic [3:0] ev, output logic [63:0] ed);
      int d;
      ev = '0;
      ed = '0;
      for (int k = 0; k < NL; k++) begin
         d = t - 5 - k * SKEW;
         if (d >= 0 && d % 4 == 0 && d / 4 < n) begin
            ev[k] = 1'b1;
            ed[k*16 +: 16] = mem_q[(b + d / 4) % 32][k];
         end
      end
   endtask

   task automatic fill_pattern();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 4; c++) mem_q[r][c] = 16'(16'h0100 * r + c);
   endtask

   task automatic fill_random();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 4; c++) mem_q[r][c] = 16'($urandom);
   endtask

   task automatic run_job(input int b, input int n, input int rs_t, input int rb, input int rn,
                          input logic has_tbl, input logic [15:0] e_first, input logic [15:0] e_last,
                          input logic addr_zero);
      int td;
      logic [3:0]  ev;
      logic [63:0] ed;
      td = t_done(n);
      @(negedge clk);
      start    = 1'b1;
      base_row = 5'(b);
      num_rows = 6'(n);
      @(posedge clk);
      for (int t = 0; t <= td + 2; t++) begin
         @(negedge clk);
         if (t == 0) start = 1'b0;
         if (t == rs_t) begin
            start    = 1'b1;
            base_row = 5'(rb);
            num_rows = 6'(rn);
         end
         if (t == rs_t + 1) start = 1'b0;
         model_lanes(t, b, n, ev, ed);
         chk("lane_valid", t, 64'(lane_valid), 64'(ev));
         chk("lane_data", t, lane_data, ed);
         chk("busy", t, 64'(busy), 64'(n > 0 && t < td));
         chk("done", t, 64'(done), 64'(t == td));
         chk("mem_en", t, 64'(mem_en), 64'(0));
         if (t < 4 * n) begin
            chk("mem_row", t, 64'(mem_row), 64'((b + t / 4) % 32));
            chk("mem_col", t, 64'(mem_col), 64'(t % 4));
         end else if (n == 0 && addr_zero) begin
            chk("mem_row_idle", t, 64'(mem_row), 64'(0));
            chk("mem_col_idle", t, 64'(mem_col), 64'(0));
         end
         if (has_tbl && n > 0) begin
            if (t == 5)      chk("first_lane0", t, 64'(lane_data[15:0]), 64'(e_first));
            if (t == td - 1) chk("last_lane3", t, 64'(lane_data[63:48]), 64'(e_last));
         end
      end
   endtask

   task automatic chk_all_zero(input string tag, input int t);
      chk({tag, "_busy"}, t, 64'(busy), 64'(0));
      chk({tag, "_done"}, t, 64'(done), 64'(0));
      chk({tag, "_lane_valid"}, t, 64'(lane_valid), 64'(0));
      chk({tag, "_lane_data"}, t, lane_data, 64'(0));
      chk({tag, "_mem_row"}, t, 64'(mem_row), 64'(0));
      chk({tag, "_mem_col"}, t, 64'(mem_col), 64'(0));
      chk({tag, "_mem_en"}, t, 64'(mem_en), 64'(0));
   endtask

   initial begin
      int b, n, rs, rb, rn;

      tbl[0] = '{0, 0, -1, 0, 0, 16'h0000, 16'h0000, 1'b1};
      tbl[1] = '{2, 3, -1, 0, 0, 16'h0200, 16'h0403, 1'b0};
      tbl[2] = '{31, 2, -1, 0, 0, 16'h1F00, 16'h0003, 1'b0};
      tbl[3] = '{5, 2, 3, 9, 4, 16'h0500, 16'h0603, 1'b0};
      tbl[4] = '{30, 4, -1, 0, 0, 16'h1E00, 16'h0103, 1'b0};
      tbl[5] = '{0, 1, -1, 0, 0, 16'h0000, 16'h0003, 1'b0};

      rst_n    = 1'b0;
      start    = 1'b0;
      base_row = '0;
      num_rows = '0;
      fill_pattern();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset", 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_job(tbl[i].base, tbl[i].num, tbl[i].rs_t, tbl[i].rbase, tbl[i].rnum,
                 1'b1, tbl[i].e_first, tbl[i].e_last, tbl[i].addr_zero);

      // Reset in the middle of FETCH: asserted after E3, released after E6
      @(negedge clk);
      start    = 1'b1;
      base_row = 5'd4;
      num_rows = 6'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("midrst", 3);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk("postrst_lane_valid", t, 64'(lane_valid), 64'(0));
         chk("postrst_busy", t, 64'(busy), 64'(0));
         chk("postrst_done", t, 64'(done), 64'(0));
      end
      run_job(6, 2, -1, 0, 0, 1'b1, 16'h0600, 16'h0703, 1'b0);

      // Randomized jobs with random memory and occasional ignored restarts
      for (int j = 0; j < 12; j++) begin
         fill_random();
         b  = $urandom_range(0, 31);
         n  = $urandom_range(0, 9);
         rs = -1;
         rb = $urandom_range(0, 31);
         rn = $urandom_range(1, 5);
         if (n > 0 && $urandom_range(0, 1) == 1) rs = $urandom_range(1, t_done(n) - 2);
         run_job(b, n, rs, rb, rn, 1'b0, 16'h0, 16'h0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
